// File: rtl/fetch_sequencer_19bit.sv
// Fetch sequencer: drives PC/IR register strobes, fetches words over a RD/ACK
// memory handshake and presents each instruction to decode over VALID/READY.
module fetch_sequencer_19bit #(
    parameter int WIDTH    = 19,
    parameter int WAIT_MAX = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             HALT,
    input  logic [WIDTH-1:0] PC_Q,
    output logic [WIDTH-1:0] PC_DIN,
    output logic             PC_LOAD,
    output logic             PC_INC,
    output logic             PC_CLR,
    output logic [WIDTH-1:0] IR_DIN,
    output logic             IR_LOAD,
    output logic [WIDTH-1:0] MEM_ADDR,
    output logic             MEM_RD,
    input  logic             MEM_ACK,
    input  logic [WIDTH-1:0] MEM_DATA,
    output logic             INSTR_VALID,
    input  logic             INSTR_READY,
    input  logic             JUMP,
    input  logic [WIDTH-1:0] JUMP_ADDR,
    output logic             TIMEOUT,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        REQ   = 2'd2,
        VALID = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       wait_expired;
    logic       accept;

    assign wait_expired = (wait_cnt == LAST_WAIT);
    assign accept       = (state == VALID) && INSTR_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // An ack on the final wait cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            INIT:  next_state = IDLE;
            IDLE:  if (START) next_state = REQ;
            REQ: begin
                if (MEM_ACK) begin
                    next_state = VALID;
                end else if (wait_expired) begin
                    next_state = IDLE;
                end
            end
            VALID: if (INSTR_READY) next_state = HALT ? IDLE : REQ;
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        PC_CLR      = (state == INIT);
        MEM_RD      = (state == REQ);
        IR_LOAD     = (state == REQ) && MEM_ACK;
        INSTR_VALID = (state == VALID);
        PC_INC      = accept && !JUMP;
        PC_LOAD     = accept && JUMP;
        BUSY        = (state != IDLE);
    end

    // Wait counter restarts on every new request; TIMEOUT stays set until the next START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        wait_cnt  <= 8'd0;
                        timeout_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (MEM_ACK) begin
                        wait_cnt <= 8'd0;
                    end else if (wait_expired) begin
                        wait_cnt  <= 8'd0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: wait_cnt <= wait_cnt;
            endcase
        end
    end

    assign TIMEOUT  = timeout_q;
    assign PC_DIN   = JUMP_ADDR;
    assign IR_DIN   = MEM_DATA;
    assign MEM_ADDR = PC_Q;

endmodule

// File: tb/tb_fetch_sequencer_19bit.sv
// Self-checking bench for fetch_sequencer_19bit with a PC register model,
// scripted memory responder and a fetch scoreboard.
module tb_fetch_sequencer_19bit;

    localparam int W = 19;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         HALT = 1'b0;
    logic [W-1:0] PC_Q;
    logic [W-1:0] PC_DIN;
    logic         PC_LOAD;
    logic         PC_INC;
    logic         PC_CLR;
    logic [W-1:0] IR_DIN;
    logic         IR_LOAD;
    logic [W-1:0] MEM_ADDR;
    logic         MEM_RD;
    logic         MEM_ACK = 1'b0;
    logic [W-1:0] MEM_DATA = '0;
    logic         INSTR_VALID;
    logic         INSTR_READY = 1'b0;
    logic         JUMP = 1'b0;
    logic [W-1:0] JUMP_ADDR = '0;
    logic         TIMEOUT;
    logic         BUSY;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } fetch_t;

    fetch_t       exp_q[$];
    logic [W-1:0] exp_pc;
    int           vectors = 0;
    int           miscompares = 0;

    fetch_sequencer_19bit #(.WIDTH(W), .WAIT_MAX(15)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HALT(HALT), .PC_Q(PC_Q),
        .PC_DIN(PC_DIN), .PC_LOAD(PC_LOAD), .PC_INC(PC_INC), .PC_CLR(PC_CLR),
        .IR_DIN(IR_DIN), .IR_LOAD(IR_LOAD), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
        .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR),
        .TIMEOUT(TIMEOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // External PC register; powers up with junk so the INIT clear is observable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_Q <= 19'h12345;
        end else if (PC_CLR) begin
            PC_Q <= '0;
        end else if (PC_LOAD) begin
            PC_Q <= PC_DIN;
        end else if (PC_INC) begin
            PC_Q <= PC_Q + 19'd1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Entered and left at posedge+1 with the DUT in REQ on entry.
    task automatic apply_stimulus(input logic [W-1:0] data, input int latency,
                                  input logic jump, input logic [W-1:0] jaddr,
                                  input logic halt);
        fetch_t got;
        for (int i = 0; i < latency; i++) begin
            #1;
            check_output("req_rd", 32'(MEM_RD), 32'd1);
            check_output("req_no_irload", 32'(IR_LOAD), 32'd0);
            next_cycle();
        end
        MEM_ACK  = 1'b1;
        MEM_DATA = data;
        exp_q.push_back('{addr: exp_pc, data: data});
        #1;
        check_output("ack_irload", 32'(IR_LOAD), 32'd1);
        if (exp_q.size() == 0) begin
            check_output("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check_output("fetch_addr", 32'(MEM_ADDR), 32'(got.addr));
            check_output("fetch_data", 32'(IR_DIN), 32'(got.data));
        end
        next_cycle();
        MEM_ACK   = 1'b0;
        JUMP      = 1'b1;
        JUMP_ADDR = 19'h00F0F;
        #1;
        check_output("valid", 32'(INSTR_VALID), 32'd1);
        check_output("valid_no_irload", 32'(IR_LOAD | MEM_RD), 32'd0);
        check_output("wait_pc_stable", 32'({PC_LOAD, PC_INC}), 32'd0);
        next_cycle();
        INSTR_READY = 1'b1;
        JUMP        = jump;
        JUMP_ADDR   = jaddr;
        HALT        = halt;
        #1;
        check_output("accept_inc", 32'(PC_INC), 32'(!jump));
        check_output("accept_load", 32'(PC_LOAD), 32'(jump));
        check_output("accept_noclr", 32'(PC_CLR), 32'd0);
        if (jump) begin
            check_output("pc_din", 32'(PC_DIN), 32'(jaddr));
            exp_pc = jaddr;
        end else begin
            exp_pc = exp_pc + 19'd1;
        end
        next_cycle();
        INSTR_READY = 1'b0;
        JUMP        = 1'b0;
        HALT        = 1'b0;
        #1;
        if (halt) begin
            check_output("halt_idle", 32'(BUSY), 32'd0);
        end else begin
            check_output("next_rd", 32'(MEM_RD), 32'd1);
            check_output("next_addr", 32'(MEM_ADDR), 32'(exp_pc));
        end
    endtask

    initial begin
        exp_pc = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_output("rst_clr", 32'(PC_CLR), 32'd1);
        check_output("rst_busy", 32'(BUSY), 32'd1);
        check_output("rst_strobes", 32'({PC_LOAD, PC_INC, IR_LOAD, MEM_RD}), 32'd0);
        check_output("rst_valid_to", 32'({INSTR_VALID, TIMEOUT}), 32'd0);
        RST = 1'b0;
        #1;
        check_output("init_clr", 32'(PC_CLR), 32'd1);
        next_cycle();
        check_output("idle_clr_gone", 32'(PC_CLR), 32'd0);
        check_output("idle_busy", 32'(BUSY), 32'd0);
        check_output("idle_strobes", 32'({PC_LOAD, PC_INC, IR_LOAD, MEM_RD}), 32'd0);
        check_output("pc_cleared", 32'(MEM_ADDR), 32'd0);

        START = 1'b1;
        next_cycle();
        START = 1'b0;
        apply_stimulus(19'h1ABCD, 2, 1'b0, 19'h0, 1'b0);
        apply_stimulus(19'h05555, 0, 1'b1, 19'h7FFFF, 1'b0);
        apply_stimulus(19'h2AAAA, 1, 1'b0, 19'h0, 1'b0);
        apply_stimulus(19'h0BEEF, 14, 1'b0, 19'h0, 1'b1);
        check_output("late_ack_no_to", 32'(TIMEOUT), 32'd0);

        // Memory never acknowledges.
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check_output("to_rd", 32'(MEM_RD), 32'd1);
            check_output("to_not_yet", 32'(TIMEOUT), 32'd0);
            next_cycle();
        end
        check_output("to_set", 32'(TIMEOUT), 32'd1);
        check_output("to_idle", 32'({BUSY, MEM_RD}), 32'd0);
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        check_output("to_cleared", 32'(TIMEOUT), 32'd0);
        check_output("restart_rd", 32'(MEM_RD), 32'd1);

        // Asynchronous reset in the middle of a request.
        #2;
        RST = 1'b1;
        #1;
        check_output("async_rd_drop", 32'(MEM_RD), 32'd0);
        check_output("async_clr", 32'(PC_CLR), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_output("reinit_clr", 32'(PC_CLR), 32'd1);
        next_cycle();
        check_output("reinit_idle", 32'({BUSY, PC_CLR}), 32'd0);
        exp_pc = '0;
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        apply_stimulus(19'h3C3C3, 3, 1'b0, 19'h0, 1'b1);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
